adsr_envelope_stage: RTL and testbench
======================================

// Module: adsr_envelope_stage
// PURPOSE
//  Downstream neighbour of the AXI4-Lite oscillator IP: consumes its signed sample stream and applies an ADSR amplitude envelope.
//  Envelope state advances once per accepted sample beat. Each output sample is input * level, scaled down by 2^ENV_W.
//  Output feeds the voice mixer / DAC path. Rates and sustain come from register fields via the codebase's AXI4-Lite regfile.
// PARAMETERS
//  SAMPLE_W  16  signed sample width, in and out
//  ENV_W     16  unsigned envelope level width; ENV_MAX = 2^ENV_W-1
// PORTS
//  ACLK           in   1         single clock, all logic rising-edge
//  ARESET         in   1         asynchronous, active-high reset
//  gate           in   1         note on(1)/off(0); sampled on accepted beats only
//  attack_rate    in   ENV_W     level increment per beat in ATTACK
//  decay_rate     in   ENV_W     level decrement per beat in DECAY
//  sustain_level  in   ENV_W     SUSTAIN target level
//  release_rate   in   ENV_W     RELEASE decrement (a shift amount if ADSR_EXP_RELEASE_EN)
//  s_tdata        in   SAMPLE_W  oscillator sample, two's complement
//  s_tvalid       in   1         input sample valid
//  s_tready       out  1         input ready
//  m_tdata        out  SAMPLE_W  enveloped sample
//  m_tvalid       out  1         output valid
//  m_tready       in   1         downstream ready
//  env_active     out  1         1 when state != IDLE
// BEHAVIOUR
//  Reset (async, immediate, also mid-beat): state=IDLE, level=0, m_tvalid=0, m_tdata=0, env_active=0, s_tready=1.
//  Handshake: s_tready = !m_tvalid | m_tready. A beat is s_tvalid & s_tready.
//  On each beat: m_tdata <= (s_tdata * {1'b0,level}) >>> ENV_W, signed with arithmetic shift/truncate. m_tvalid<=1. Latency 1 clk.
//  No beat & m_tready: m_tvalid<=0. m_tvalid & !m_tready: m_tdata/m_tvalid held stable, level/state frozen.
//  The product uses level before this beat's update. The new level applies from the next beat.
//  FSM (evaluated only on beats; gate sampled at the beat):
//   IDLE:    gate=1 -> ATTACK (level steps this beat); else level=0
//   ATTACK:  gate=0 -> RELEASE; else level=min(level+attack_rate, ENV_MAX), computed at ENV_W+1 bits; hits ENV_MAX -> DECAY
//   DECAY:   gate=0 -> RELEASE; else level=max(level-decay_rate, sustain_level); hits sustain_level -> SUSTAIN
//   SUSTAIN: gate=0 -> RELEASE; else level=sustain_level (tracks live changes)
//   RELEASE: gate=1 -> ATTACK from current level (no reset to 0); else level=max(level-release_rate, 0); hits 0 -> IDLE
//  A transition beat applies the new state's step in the same beat (e.g. DECAY->RELEASE subtracts release_rate).
//  Subtraction never wraps: clamp at floor. Addition never wraps: clamp at ENV_MAX.
//  attack_rate=0 holds in ATTACK indefinitely (legal). sustain_level>=current level in DECAY -> SUSTAIN on that beat.
//  Retrigger from SUSTAIN/DECAY requires gate=0 on at least one beat.
//  Rate/sustain inputs are quasi-static and used combinationally on the beat.
// CONFIGURATION
//  ADSR_EXP_RELEASE_EN defined:
//   RELEASE step = (level >> release_rate[3:0]) + 1, clamped at 0 (exponential decay, always terminates).
//  Undefined: linear RELEASE using the full release_rate as above. release_rate=0 then holds in RELEASE.
// TESTING
//  1 Reset: ARESET=1 mid-stream with m_tvalid=1 -> m_tvalid=0, m_tdata=0, env_active=0 in the same cycle. No beat accepted.
//  2 Attack: gate=1, attack_rate=0x4000, 4 beats -> levels 0x4000, 0x8000, 0xC000, 0xFFFF (saturated), state DECAY.
//  3 Decay/sustain: decay_rate=0x1000, sustain=0x8000 from 0xFFFF -> 7 beats to 0x8FFF, 8th clamps 0x8000, state SUSTAIN.
//    Then s_tdata=0x4000 -> m_tdata=0x2000, and s_tdata=0xC000 -> m_tdata=0xE000.
//  4 Release: gate=0, release_rate=0x2000 from 0x8000 -> 4 beats to 0, state IDLE, env_active=0.
//    Gate=1 mid-release at 0x4000 -> ATTACK continues from 0x4000.
//  5 Backpressure: m_tready=0 for 5 clks with s_tvalid=1 -> s_tready=0, m_tdata stable, level unchanged.
//    Release m_tready -> one beat per clk, no sample lost or duplicated.
//  6 ADSR_EXP_RELEASE_EN: level=0x8000, release_rate=1 -> next beat 0x3FFF.
//    Reaches 0 and IDLE in finite beats.

Source files
------------

// File: rtl/adsr_envelope_stage.sv
// ADSR amplitude envelope applied to a signed sample stream with a valid/ready handshake.
// Optional build macro ADSR_EXP_RELEASE_EN selects exponential instead of linear release.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | note off, level held at 0
// ST_ATTACK  | level rising by attack_rate per beat, saturating at ENV_MAX
// ST_DECAY   | level falling by decay_rate per beat towards sustain_level
// ST_SUSTAIN | level follows sustain_level while the gate stays high
// ST_RELEASE | level falling towards 0 after the gate drops
module adsr_envelope_stage #(
    parameter int SAMPLE_W = 16,
    parameter int ENV_W    = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       gate,
    input  logic [ENV_W-1:0]           attack_rate,
    input  logic [ENV_W-1:0]           decay_rate,
    input  logic [ENV_W-1:0]           sustain_level,
    input  logic [ENV_W-1:0]           release_rate,
    input  logic signed [SAMPLE_W-1:0] s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic signed [SAMPLE_W-1:0] m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       env_active
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    localparam logic [ENV_W-1:0] ENV_MAX = '1;
    localparam int PROD_W = SAMPLE_W + ENV_W + 1;

    state_t                     state_q, state_d;
    logic [ENV_W-1:0]           level_q, level_d;
    logic signed [SAMPLE_W-1:0] m_tdata_q, m_tdata_d;
    logic                       m_tvalid_q, m_tvalid_d;

    logic                       beat;
    logic signed [PROD_W-1:0]   product;

    logic [ENV_W:0]             attack_sum;
    logic                       attack_full;
    logic [ENV_W-1:0]           attack_level;

    logic                       decay_done;
    logic [ENV_W-1:0]           decay_level;

    logic [ENV_W:0]             release_step;
    logic                       release_empty;
    logic [ENV_W-1:0]           release_level;

    assign s_tready   = !m_tvalid_q || m_tready;
    assign beat       = s_tvalid && s_tready;
    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign env_active = (state_q != ST_IDLE);

    // The zero-extended level keeps the multiply signed without flipping large levels negative.
    assign product = s_tdata * $signed({1'b0, level_q});

    // All step arithmetic is one bit wider than the level so nothing wraps before clamping.
    always_comb begin
        attack_sum   = {1'b0, level_q} + {1'b0, attack_rate};
        attack_full  = (attack_sum >= {1'b0, ENV_MAX});
        attack_level = attack_full ? ENV_MAX : attack_sum[ENV_W-1:0];
    end

    always_comb begin
        decay_done  = ({1'b0, level_q} <= ({1'b0, sustain_level} + {1'b0, decay_rate}));
        decay_level = decay_done ? sustain_level : (level_q - decay_rate);
    end

`ifdef ADSR_EXP_RELEASE_EN
    logic [ENV_W-1:0] release_shift;

    // Step proportional to the level plus one, so the tail still reaches zero.
    always_comb begin
        release_shift = level_q >> release_rate[3:0];
        release_step  = {1'b0, release_shift} + {{ENV_W{1'b0}}, 1'b1};
    end
`else
    always_comb begin
        release_step = {1'b0, release_rate};
    end
`endif

    always_comb begin
        release_empty = ({1'b0, level_q} <= release_step);
        release_level = release_empty ? '0 : (level_q - release_step[ENV_W-1:0]);
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;

        if (beat) begin
            m_tdata_d  = SAMPLE_W'(product >>> ENV_W);
            m_tvalid_d = 1'b1;

            // A gate-driven transition applies the destination state's step on the same beat.
            case (state_q)
                ST_IDLE: begin
                    if (gate) begin
                        level_d = attack_level;
                        state_d = attack_full ? ST_DECAY : ST_ATTACK;
                    end else begin
                        level_d = '0;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        level_d = release_level;
                        state_d = release_empty ? ST_IDLE : ST_RELEASE;
                    end else begin
                        level_d = attack_level;
                        state_d = attack_full ? ST_DECAY : ST_ATTACK;
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        level_d = release_level;
                        state_d = release_empty ? ST_IDLE : ST_RELEASE;
                    end else begin
                        level_d = decay_level;
                        state_d = decay_done ? ST_SUSTAIN : ST_DECAY;
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        level_d = release_level;
                        state_d = release_empty ? ST_IDLE : ST_RELEASE;
                    end else begin
                        level_d = sustain_level;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        level_d = attack_level;
                        state_d = attack_full ? ST_DECAY : ST_ATTACK;
                    end else begin
                        level_d = release_level;
                        state_d = release_empty ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

endmodule

// File: tb/tb_adsr_envelope_stage.sv
// Scoreboard bench for adsr_envelope_stage: directed beats push expected outputs, a monitor pops on transfer.
// With s_tdata = 0x4000 every expected output is simply level >> 2.
module tb_adsr_envelope_stage;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        gate = 1'b0;
    logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        env_active;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          out_idx = 0;
    logic [15:0] exp_q[$];
    logic [15:0] held_exp, b26_exp;

    adsr_envelope_stage #(.SAMPLE_W(16), .ENV_W(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .env_active(env_active)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge ACLK) begin
        logic [15:0] e;
        if (!ARESET && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_out: got %h expected no output", m_tdata);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("out%0d", out_idx), {16'h0, m_tdata}, {16'h0, e});
            end
            out_idx++;
        end
    end

    task automatic send(input logic g, input logic [15:0] d, input logic [15:0] e);
        int n;
        gate     = g;
        s_tdata  = d;
        s_tvalid = 1'b1;
        exp_q.push_back(e);
        n = 0;
        @(negedge ACLK);
        while (!s_tready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (!s_tready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: got s_tready=%b expected 1", s_tready);
        end
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        attack_rate   = 16'h4000;
        decay_rate    = 16'h1000;
        sustain_level = 16'h8000;
        release_rate  = 16'h2000;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("rst_m_tdata", {16'h0, m_tdata}, 32'h0);
        check("rst_env_active", {31'h0, env_active}, 32'h0);
        check("rst_s_tready", {31'h0, s_tready}, 32'h1);
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;

        // attack: 0 -> 4000 -> 8000 -> C000 -> FFFF
        send(1'b1, 16'h4000, 16'h0000);
        check("attack_active", {31'h0, env_active}, 32'h1);
        send(1'b1, 16'h4000, 16'h1000);
        send(1'b1, 16'h4000, 16'h2000);
        send(1'b1, 16'h4000, 16'h3000);
        // decay FFFF -> 8FFF in 7 beats, 8th clamps at 8000
        send(1'b1, 16'h4000, 16'h3FFF);
        send(1'b1, 16'h4000, 16'h3BFF);
        send(1'b1, 16'h4000, 16'h37FF);
        send(1'b1, 16'h4000, 16'h33FF);
        send(1'b1, 16'h4000, 16'h2FFF);
        send(1'b1, 16'h4000, 16'h2BFF);
        send(1'b1, 16'h4000, 16'h27FF);
        send(1'b1, 16'h4000, 16'h23FF);
        // sustain at 8000, signed samples
        send(1'b1, 16'h4000, 16'h2000);
        send(1'b1, 16'hC000, 16'hE000);

`ifdef ADSR_EXP_RELEASE_EN
        release_rate = 16'h0001;
        send(1'b0, 16'h4000, 16'h2000);
        send(1'b0, 16'h4000, 16'h0FFF);
        for (int n = 0; n < 40 && env_active; n++) send(1'b0, 16'h0000, 16'h0000);
        check("exp_rel_idle", {31'h0, env_active}, 32'h0);
        send(1'b0, 16'h4000, 16'h0000);
        send(1'b1, 16'h4000, 16'h0000);
        send(1'b1, 16'h4000, 16'h1000);
        send(1'b0, 16'h4000, 16'h2000);
        send(1'b1, 16'h4000, 16'h0FFF);
        send(1'b1, 16'h4000, 16'h1FFF);
        held_exp = 16'h1FFF;
        b26_exp  = 16'h2FFF;
`else
        // release 8000 -> 6000 -> 4000 -> 2000 -> 0
        send(1'b0, 16'h4000, 16'h2000);
        send(1'b0, 16'h4000, 16'h1800);
        send(1'b0, 16'h4000, 16'h1000);
        check("rel_active", {31'h0, env_active}, 32'h1);
        send(1'b0, 16'h4000, 16'h0800);
        check("rel_idle", {31'h0, env_active}, 32'h0);
        send(1'b0, 16'h4000, 16'h0000);
        // retrigger mid-release from 4000
        send(1'b1, 16'h4000, 16'h0000);
        send(1'b1, 16'h4000, 16'h1000);
        send(1'b0, 16'h4000, 16'h2000);
        send(1'b0, 16'h4000, 16'h1800);
        send(1'b1, 16'h4000, 16'h1000);
        send(1'b1, 16'h4000, 16'h2000);
        held_exp = 16'h2000;
        b26_exp  = 16'h3000;
`endif

        // backpressure: output held, input stalled, level frozen
        m_tready = 1'b0;
        repeat (5) begin
            @(negedge ACLK);
            check("bp_s_tready", {31'h0, s_tready}, 32'h0);
            check("bp_m_tvalid", {31'h0, m_tvalid}, 32'h1);
            check("bp_m_tdata", {16'h0, m_tdata}, {16'h0, held_exp});
        end
        @(posedge ACLK);
        #1;
        m_tready = 1'b1;
        send(1'b1, 16'h4000, b26_exp);
        send(1'b1, 16'h4000, 16'h3FFF);
        send(1'b1, 16'h4000, 16'h3BFF);

        // asynchronous reset mid-cycle while an output is pending
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        @(negedge ACLK);
        check("pre_rst_valid", {31'h0, m_tvalid}, 32'h1);
        #2;
        ARESET = 1'b1;
        #1;
        check("mid_rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("mid_rst_m_tdata", {16'h0, m_tdata}, 32'h0);
        check("mid_rst_env_active", {31'h0, env_active}, 32'h0);
        check("mid_rst_s_tready", {31'h0, s_tready}, 32'h1);
        exp_q.delete();
        @(posedge ACLK);
        #1;
        ARESET   = 1'b0;
        m_tready = 1'b1;
        send(1'b0, 16'h4000, 16'h0000);
        s_tvalid = 1'b0;
        repeat (4) @(posedge ACLK);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
